// File: rtl/gray_bbox_tracker_pkg.sv
`default_nettype none
// =====================================================================
// gray_bbox_tracker_pkg : coordinate widths, limits, FSM state encoding
// Revision 1.0
// =====================================================================
package gray_bbox_tracker_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 16;

  localparam logic [COORD_W-1:0] COORD_MAX = 11'h7FF;
  localparam logic [CNT_W-1:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LATCH  = 2'd2
  } state_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 11'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_bbox_tracker_pos_counter.sv
`default_nettype none
// =====================================================================
// gray_bbox_tracker_pos_counter : sync edge detect and saturating x/y
// Revision 1.0
// =====================================================================
module gray_bbox_tracker_pos_counter
  import gray_bbox_tracker_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               href,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               vs_rise,
  output logic               vs_fall
);

  logic               r_vs_d;
  logic               r_hs_d;
  logic               r_primed;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_hs_fall;

  // r_primed suppresses a false rise when reset releases with vsync already high
  assign vs_rise   = vsync & ~r_vs_d & r_primed;
  assign vs_fall   = ~vsync & r_vs_d;
  assign w_hs_fall = ~href & r_hs_d;
  assign x         = r_x;
  assign y         = r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d   <= 1'b0;
      r_hs_d   <= 1'b0;
      r_primed <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_vs_d   <= vsync;
      r_hs_d   <= href;
      r_primed <= 1'b1;

      if (vs_rise || w_hs_fall) begin
        r_x <= '0;
      end else if (href) begin
        r_x <= sat_inc(r_x);
      end

      // Lines only advance inside a frame, including the vsync-fall clock
      if (vs_rise) begin
        r_y <= '0;
      end else if (w_hs_fall && (vsync || r_vs_d)) begin
        r_y <= sat_inc(r_y);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_bbox_tracker.sv
`default_nettype none
// =====================================================================
// gray_bbox_tracker : per-frame foreground bounding box with overlay
// Revision 1.0
// =====================================================================
module gray_bbox_tracker
  import gray_bbox_tracker_pkg::*;
#(
  parameter logic [COORD_W-1:0] IMG_HDISP    = 11'd640,
  parameter logic [COORD_W-1:0] IMG_VDISP    = 11'd480,
  parameter bit                 FG_BLACK     = 1'b1,
  parameter logic [CNT_W-1:0]   MIN_PIXELS   = 16'd16,
  parameter logic [7:0]         OVERLAY_GRAY = 8'h80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic [7:0]         per_img_Gray,
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic [7:0]         post_img_Gray,
  output logic               box_valid,
  output logic               box_found,
  output logic [COORD_W-1:0] box_xmin,
  output logic [COORD_W-1:0] box_xmax,
  output logic [COORD_W-1:0] box_ymin,
  output logic [COORD_W-1:0] box_ymax
);

  localparam logic [7:0] FG_VALUE = FG_BLACK ? 8'h00 : 8'hFF;

  state_t             r_state;
  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymin;
  logic [COORD_W-1:0] r_ymax;
  logic [CNT_W-1:0]   r_cnt;

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_vs_rise;
  logic               w_vs_fall;
  logic               w_fg;
  logic               w_on_row;
  logic               w_on_col;
  logic               w_edge;

  gray_bbox_tracker_pos_counter u_pos (
    .clk     (clk),
    .rst     (rst),
    .vsync   (per_frame_vsync),
    .href    (per_frame_href),
    .x       (w_x),
    .y       (w_y),
    .vs_rise (w_vs_rise),
    .vs_fall (w_vs_fall)
  );

  assign w_fg = (r_state == ST_ACTIVE) && per_frame_href &&
                (w_x < IMG_HDISP) && (w_y < IMG_VDISP) &&
                (per_img_Gray == FG_VALUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
      r_cnt  <= '0;
    end else if (w_vs_rise) begin
      r_xmin <= COORD_MAX;
      r_ymin <= COORD_MAX;
      r_xmax <= '0;
      r_ymax <= '0;
      r_cnt  <= '0;
    end else if (w_fg) begin
      if (w_x < r_xmin) r_xmin <= w_x;
      if (w_x > r_xmax) r_xmax <= w_x;
      if (w_y < r_ymin) r_ymin <= w_y;
      if (w_y > r_ymax) r_ymax <= w_y;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 16'd1;
    end
  end

  // LATCH may see the next vsync rise when vsync dropped for a single clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      box_valid <= 1'b0;
      box_found <= 1'b0;
      box_xmin  <= '0;
      box_xmax  <= '0;
      box_ymin  <= '0;
      box_ymax  <= '0;
    end else begin
      box_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_vs_rise) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_vs_fall) r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          box_valid <= 1'b1;
          if (r_cnt >= MIN_PIXELS) begin
            box_found <= 1'b1;
            box_xmin  <= r_xmin;
            box_xmax  <= r_xmax;
            box_ymin  <= r_ymin;
            box_ymax  <= r_ymax;
          end else begin
            box_found <= 1'b0;
            box_xmin  <= '0;
            box_xmax  <= '0;
            box_ymin  <= '0;
            box_ymax  <= '0;
          end
          r_state <= w_vs_rise ? ST_ACTIVE : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_on_row = ((w_y == box_ymin) || (w_y == box_ymax)) &&
                    (w_x >= box_xmin) && (w_x <= box_xmax);
  assign w_on_col = ((w_x == box_xmin) || (w_x == box_xmax)) &&
                    (w_y >= box_ymin) && (w_y <= box_ymax);
  assign w_edge   = box_found && per_frame_href && (w_on_row || w_on_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Gray    <= '0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_img_Gray    <= w_edge ? OVERLAY_GRAY : per_img_Gray;
    end
  end

endmodule

`default_nettype wire
